// File: rtl/elliptic_curve_structs.sv
// elliptic_curve_structs: shared curve point type and point-op selector
package elliptic_curve_structs;
  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } curve_point_t;
  typedef enum logic {DBL = 1'b0, ADD = 1'b1} pt_op_t;
endpackage

// File: rtl/point_mult_sequencer.sv
// point_mult_sequencer: MSB-first double-and-add Q = k*P over an external point-op unit; POINT_MULT_CONST_TIME_EN selects the fixed 512-op schedule
module point_mult_sequencer
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] k,
  input  curve_point_t p_in,
  output logic         busy,
  output logic         done,
  output curve_point_t result,
  output logic         result_inf,
  output logic         op_start,
  output pt_op_t       op_sel,
  output curve_point_t op_a,
  output curve_point_t op_b,
  input  logic         op_done,
  input  curve_point_t op_result
);
`ifdef POINT_MULT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_DONE} state_t;
  state_t       st, st_n;
  logic [255:0] k_reg, k_n;
  curve_point_t p_reg, p_n, r, r_n;
  logic         r_inf, r_inf_n;
  logic [7:0]   i, i_n;
  logic         bit_i;
  assign bit_i = k_reg[i];
  always_comb begin
    st_n = st;
    k_n = k_reg;
    p_n = p_reg;
    r_n = r;
    r_inf_n = r_inf;
    i_n = i;
    case (st)
      S_IDLE: if (start) begin
        k_n = k;
        p_n = p_in;
        i_n = 8'd255;
        r_inf_n = 1'b1;
        st_n = CT ? S_DBL : S_SCAN;
      end
      S_SCAN:
        if (k_reg == '0) st_n = S_DONE;
        else if (!bit_i) i_n = i - 8'd1;
        else begin
          r_n = p_reg;
          r_inf_n = 1'b0;
          st_n = (i == 8'd0) ? S_DONE : S_DBL;
          i_n = (i == 8'd0) ? i : i - 8'd1;
        end
      S_DBL: st_n = S_DBL_WAIT;
      S_DBL_WAIT: if (op_done) begin
        r_n = (CT && r_inf) ? r : op_result;
        st_n = (CT || bit_i) ? S_ADD : S_NEXT;
      end
      S_ADD: st_n = S_ADD_WAIT;
      S_ADD_WAIT: if (op_done) begin
        st_n = S_NEXT;
        // while R is infinity the unit's answer is junk; the first set bit seeds R with P
        if (CT && r_inf) begin
          r_n = bit_i ? p_reg : r;
          r_inf_n = !bit_i;
        end else r_n = (!CT || bit_i) ? op_result : r;
      end
      S_NEXT: begin
        st_n = (i == 8'd0) ? S_DONE : S_DBL;
        i_n = (i == 8'd0) ? i : i - 8'd1;
      end
      S_DONE: st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      k_reg <= '0;
      p_reg <= '0;
      r <= '0;
      r_inf <= 1'b1;
      i <= 8'd255;
      result <= '0;
      result_inf <= 1'b1;
    end else begin
      st <= st_n;
      k_reg <= k_n;
      p_reg <= p_n;
      r <= r_n;
      r_inf <= r_inf_n;
      i <= i_n;
      if (st_n == S_DONE) begin
        result <= r_n;
        result_inf <= r_inf_n;
      end
    end
  end
  assign busy = (st != S_IDLE) && (st != S_DONE);
  assign done = (st == S_DONE);
  assign op_start = (st == S_DBL) || (st == S_ADD);
  assign op_sel = (st == S_ADD || st == S_ADD_WAIT) ? ADD : DBL;
  assign op_a = (CT && r_inf) ? p_reg : r;
  assign op_b = p_reg;
endmodule

// File: tb/tb_point_mult_sequencer.sv
// tb_point_mult_sequencer: scoreboard bench with a symbolic 4-cycle point-op mock (x = multiple of P, y = base id)
module tb_point_mult_sequencer;
  import elliptic_curve_structs::*;
  localparam int LAT = 4;
`ifdef POINT_MULT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_done = 1'b0;
  logic [255:0] k = '0;
  curve_point_t p_in = '0, op_result = '0, result, op_a, op_b;
  logic busy, done, result_inf, op_start;
  pt_op_t op_sel;
  point_mult_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .p_in(p_in), .busy(busy), .done(done),
    .result(result), .result_inf(result_inf), .op_start(op_start), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .op_done(op_done), .op_result(op_result));
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    logic inf;
    int unsigned done_cyc;
    int dbl;
    int add;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int n_dbl = 0, n_add = 0;
  bit inflight = 0, busy_gap = 0;
  curve_point_t p_cur = '0;
  function automatic void chk(string name, logic [255:0] act, logic [255:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction
  function automatic int msb_of(logic [255:0] v);
    int m = -1;
    for (int j = 0; j < 256; j++) if (v[j]) m = j;
    return m;
  endfunction
  function automatic int pop_of(logic [255:0] v);
    int c = 0;
    for (int j = 0; j < 256; j++) c += int'(v[j]);
    return c;
  endfunction
  // cycles from the accepted start edge to the done cycle for a unit of latency LAT
  function automatic int unsigned lat_of(logic [255:0] v);
    int m = msb_of(v);
    int unsigned t;
    if (CT) return 1 + 256 * (2 * (LAT + 1) + 1);
    if (m < 0) return 2;
    t = 256 - m;
    for (int j = m - 1; j >= 0; j--) t += (LAT + 2) + (v[j] ? LAT + 1 : 0);
    return t + 1;
  endfunction
  // mock point-op unit: a point is symbolically x*P with base id y
  initial forever begin
    curve_point_t a, b;
    pt_op_t s;
    @(negedge clk);
    if (op_start) begin
      a = op_a;
      b = op_b;
      s = op_sel;
      if (s == DBL) n_dbl++;
      else begin
        n_add++;
        chk("op_b_is_p", b, p_cur);
      end
      repeat (LAT) @(posedge clk);
      #1;
      if (busy) chk("op_a_stable", op_a, a);
      op_result.x = (s == DBL) ? a.x << 1 : a.x + b.x;
      op_result.y = a.y;
      op_done = 1'b1;
      @(posedge clk);
      #1 op_done = 1'b0;
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (inflight && !done && !busy) busy_gap = 1;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 256'(done), 256'(0));
      else begin
        e = sb.pop_front();
        chk("result_inf", 256'(result_inf), 256'(e.inf));
        if (!e.inf) begin
          chk("result_x", result.x, e.x);
          chk("result_y", result.y, e.y);
        end
        chk("done_cycle", 256'(cyc), 256'(e.done_cyc));
        chk("dbl_count", 256'(n_dbl), 256'(e.dbl));
        chk("add_count", 256'(n_add), 256'(e.add));
        chk("busy_gap", 256'(busy_gap), 256'(0));
      end
      n_dbl = 0;
      n_add = 0;
      busy_gap = 0;
      inflight = 0;
    end
  end
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32+:32] = $urandom;
    return v;
  endfunction
  task automatic run(input logic [255:0] kv, input bit stray);
    exp_t e;
    int t = 0;
    int m = msb_of(kv);
    @(posedge clk);
    #1;
    p_cur.x = 256'd1;
    p_cur.y = rnd256();
    start = 1'b1;
    k = kv;
    p_in = p_cur;
    e.x = kv;
    e.y = p_cur.y;
    e.inf = (kv == '0);
    e.done_cyc = cyc + lat_of(kv);
    e.dbl = CT ? 256 : (m < 0 ? 0 : m);
    e.add = CT ? 256 : (m < 0 ? 0 : pop_of(kv) - 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    inflight = 1;
    k = rnd256();
    p_in = '{x: rnd256(), y: rnd256()};
    if (stray) begin
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    while (sb.size() != 0 && t < 6000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 256'(sb.size()), 256'(0));
      sb.delete();
      inflight = 0;
    end
    repeat (LAT + 3) @(posedge clk);
  endtask
  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_op_start"}, 256'(op_start), 256'(0));
    chk({tag, "_result"}, result, 256'(0));
    chk({tag, "_result_inf"}, 256'(result_inf), 256'(1));
  endtask
  initial begin
    logic [255:0] v;
    int t;
    repeat (3) @(posedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    run(256'd0, 0);
    run(256'd1, 0);
    run(256'd3, 0);
    run('1, 1);
    v = '0;
    v[255] = 1'b1;
    run(v, 0);
    run(256'd6, 0);
    // abort k=5 while the ADD is outstanding; its late op_done must be ignored
    @(posedge clk);
    #1;
    p_cur = '{x: 256'd1, y: rnd256()};
    start = 1'b1;
    k = 256'd5;
    p_in = p_cur;
    @(posedge clk);
    #1 start = 1'b0;
    t = 0;
    while (!(op_start && op_sel == ADD) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) chk("add_timeout", 256'(t), 256'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    check_reset_vals("abort");
    n_dbl = 0;
    n_add = 0;
    run(256'd2, 0);
    for (int n = 0; n < 8; n++) begin
      v = rnd256();
      if (n % 3 == 1) v = v & rnd256() & rnd256();
      if (n % 3 == 2) v = v >> $urandom_range(250, 1);
      run(v, n == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/point_mult_sequencer.md
POINT_MULT_SEQUENCER -- requirements
Module: point_mult_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  in  1  one-cycle request to begin Q = k*P.
REQ-004 SHALL have: k  in  256  scalar, sampled on accepted start.
REQ-005 SHALL have: p_in  in  curve_point_t  base point P, sampled on accepted start.
REQ-006 SHALL have: busy  out  1  high from the cycle after accepted start until done.
REQ-007 SHALL have: done  out  1  one-cycle completion pulse.
REQ-008 SHALL have: result  out  curve_point_t  Q; result_inf  out  1  Q is point at infinity.
REQ-009 SHALL have: op_start  out  1  one-cycle pulse to the external point-op unit; op_sel  out  pt_op_t  DBL or ADD.
REQ-010 SHALL have: op_a, op_b  out  curve_point_t  operands; op_done  in  1  result-valid pulse; op_result  in  curve_point_t.

Function
REQ-011 SHALL implement MSB-first double-and-add with internal accumulator R, flag R_inf, bit index i (8 bit), latched k_reg and P_reg.
REQ-012 States SHALL be IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT, DONE.
REQ-013 IDLE: start=1 SHALL latch k, p_in, set i=255, R_inf=1, go SCAN; start SHALL be ignored in every other state.
REQ-014 SCAN: k_reg==0 -> DONE with result_inf=1; k_reg[i]==0 -> i-1, stay (one cycle per leading zero); k_reg[i]==1 -> R=P_reg, R_inf=0, then DONE if i==0 else i-1 and DBL.
REQ-015 DBL: op_start=1, op_sel=DBL, op_a=R, one cycle, -> DBL_WAIT.
REQ-016 DBL_WAIT: on op_done, R=op_result; -> ADD if k_reg[i]==1 else NEXT.
REQ-017 ADD: op_start=1, op_sel=ADD, op_a=R, op_b=P_reg, -> ADD_WAIT; on op_done R=op_result, -> NEXT.
REQ-018 NEXT: i==0 -> DONE else i-1 -> DBL; i SHALL never wrap below 0.
REQ-019 DONE: done=1 for exactly one cycle, result=R, result_inf=R_inf, -> IDLE.
REQ-020 result/result_inf SHALL hold until the next done; op_a/op_b SHALL hold stable from op_start until op_done.
REQ-021 op_done outside DBL_WAIT/ADD_WAIT SHALL be ignored; op_done in the same cycle as op_start SHALL NOT occur (unit latency >=1).
REQ-022 No timeout; sequencer SHALL wait indefinitely for op_done.

Reset
REQ-023 rst SHALL force IDLE immediately, including mid-operation; busy=0, done=0, op_start=0, result=0, result_inf=1, R_inf=1, i=255.
REQ-024 An op_done arriving after a mid-operation reset SHALL be ignored.

Configuration
REQ-025 Macro POINT_MULT_CONST_TIME_EN defined: SCAN SHALL be bypassed; every i from 255 to 0 SHALL issue one DBL then one ADD (exactly 512 ops for any k, including 0).
REQ-026 With the macro: while R_inf=1, operands SHALL be P_reg and results discarded; ADD result written only if k_reg[i]==1; when R_inf=1 and k_reg[i]==1, R=P_reg, R_inf=0 instead.
REQ-027 Without the macro: behaviour SHALL be exactly REQ-014..REQ-018 (data-dependent op count).

Structure
REQ-028 typedef pt_op_t (DBL=0, ADD=1) SHALL be added to package elliptic_curve_structs; curve_point_t SHALL be taken from it.
REQ-029 State encoding SHALL be local to the module; no sub-module; point arithmetic remains in the external unit.

Verification (mock op unit, fixed 4-cycle latency, symbolic points)
REQ-030 k=0, start at cycle 0 -> done at cycle 2, result_inf=1, zero op_start pulses.
REQ-031 k=1 -> done at cycle 257, result=P, result_inf=0, zero ops.
REQ-032 k=3 -> ops exactly DBL(P), ADD(2P,P); result=3P.
REQ-033 k=2^256-1 -> 255 DBL and 255 ADD alternating; done pulse once; busy high throughout.
REQ-034 rst asserted in ADD_WAIT of k=5, late op_done delivered -> outputs at reset values, no done; new start k=2 -> result=2P.
REQ-035 With POINT_MULT_CONST_TIME_EN, k=0 and k=6 -> both 512 ops, identical done cycle; results infinity and 6P.
